// File: rtl/ldiv_pkg.sv
// ---------------------------------------------------------------------------
// ldiv_pkg
// Shared definitions for the long-divider family (ldiv / lmul).
//   lmul_latency(qw)    : lmul register depth, input edge to output edge + 1
//   lmul_rec_w(..)      : packed width of one lmul stage record
//   abs_mag(x)          : sign/magnitude split helper, magnitude of a signed
//                         value sign-extended to ABS_W bits
//   lmul_rec_t          : stage-record layout at the default widths; modules
//                         rebuild the same field order at their own widths
//                         because a package cannot be parameterised
// ---------------------------------------------------------------------------
package ldiv_pkg;

   localparam int unsigned ABS_W       = 64;
   localparam int unsigned LMUL_DEF_NW = 10;
   localparam int unsigned LMUL_DEF_DW = 10;
   localparam int unsigned LMUL_DEF_QW = 10;

   // Stage record: {valid, neg, mag, denominator, remainder, acc}
   typedef struct packed {
      logic                                valid;
      logic                                neg;
      logic [LMUL_DEF_QW-1:0]              mag;
      logic [LMUL_DEF_DW-1:0]              denominator;
      logic [LMUL_DEF_NW-1:0]              remainder;
      logic [LMUL_DEF_QW+LMUL_DEF_DW-1:0]  acc;
   } lmul_rec_t;

   // Stage 0 + Q shift-add stages + output stage
   function automatic int unsigned lmul_latency(input int unsigned qw);
      return qw + 32'd2;
   endfunction

   function automatic int unsigned lmul_rec_w(input int unsigned nw,
                                              input int unsigned dw,
                                              input int unsigned qw);
      return 32'd2 + qw + dw + nw + (qw + dw);
   endfunction

   // Magnitude of a two's-complement value; the most-negative input maps to
   // its true magnitude when the caller keeps only the original width.
   function automatic logic [ABS_W-1:0] abs_mag(input logic signed [ABS_W-1:0] x);
      logic [ABS_W-1:0] m;
      if (x[ABS_W-1]) m = $unsigned(-x);
      else            m = $unsigned(x);
      return m;
   endfunction

endpackage

// File: rtl/lmul_stage.sv
// ---------------------------------------------------------------------------
// lmul_stage
// One shift-add step of the lmul accumulator. Consumes quotient magnitude
// bit BIT_INDEX (MSB-first overall) and forwards the rest of the record.
//   clk, reset : clock, asynchronous active-high reset
//   rec_i      : stage record from the previous stage (packed)
//   rec_o      : registered stage record for the next stage (packed)
// ---------------------------------------------------------------------------
module lmul_stage
   import ldiv_pkg::*;
#(
   parameter int unsigned NUMERATOR_WIDTH   = 10,
   parameter int unsigned DENOMINATOR_WIDTH = 10,
   parameter int unsigned QUOTIENT_WIDTH    = 10,
   parameter int unsigned BIT_INDEX         = 0
) (
   input  logic                                                            clk,
   input  logic                                                            reset,
   input  logic [lmul_rec_w(NUMERATOR_WIDTH, DENOMINATOR_WIDTH, QUOTIENT_WIDTH)-1:0] rec_i,
   output logic [lmul_rec_w(NUMERATOR_WIDTH, DENOMINATOR_WIDTH, QUOTIENT_WIDTH)-1:0] rec_o
);

   localparam int unsigned NW = NUMERATOR_WIDTH;
   localparam int unsigned DW = DENOMINATOR_WIDTH;
   localparam int unsigned QW = QUOTIENT_WIDTH;
   localparam int unsigned AW = QW + DW;

   typedef struct packed {
      logic          valid;
      logic          neg;
      logic [QW-1:0] mag;
      logic [DW-1:0] denominator;
      logic [NW-1:0] remainder;
      logic [AW-1:0] acc;
   } rec_t;

   rec_t in_s;
   rec_t rec_d;
   rec_t rec_q;

   assign in_s = rec_i;

   // acc is wide enough for the full product, so the shift never drops a set bit
   always_comb begin
      rec_d     = in_s;
      rec_d.acc = (in_s.acc << 1) + (in_s.mag[BIT_INDEX] ? AW'(in_s.denominator) : AW'(0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rec_q <= '0;
      else       rec_q <= rec_d;
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/lmul.sv
// ---------------------------------------------------------------------------
// lmul
// Pipelined signed-by-unsigned multiply-accumulate:
//   numerator = quotient * denominator + remainder
// Recombines a truncating-division triple into its numerator and flags when
// the exact result does not fit NUMERATOR_WIDTH signed bits. Fixed latency,
// one result per clock, no backpressure.
//
// Ports
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   quotient_in     : signed quotient,       QUOTIENT_WIDTH bits
//   denominator_in  : unsigned denominator,  DENOMINATOR_WIDTH bits
//   remainder_in    : signed remainder,      NUMERATOR_WIDTH bits
//   valid_in        : triple sampled on this edge
//   numerator_out   : low NUMERATOR_WIDTH bits of q*d+r
//   overflow_out    : exact q*d+r not representable in NUMERATOR_WIDTH bits
//   check_fail_out  : triple inconsistent with truncating division
//   valid_out       : outputs hold a result this cycle
//
// Build option
//   LMUL_CHECK_EN : when defined, check_fail_out is computed in the output
//                   stage; otherwise it is constant 0 and no comparator exists.
// ---------------------------------------------------------------------------
module lmul
   import ldiv_pkg::*;
#(
   parameter int unsigned NUMERATOR_WIDTH   = 10,
   parameter int unsigned DENOMINATOR_WIDTH = 10,
   parameter int unsigned QUOTIENT_WIDTH    = 10
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic signed [QUOTIENT_WIDTH-1:0]    quotient_in,
   input  logic        [DENOMINATOR_WIDTH-1:0] denominator_in,
   input  logic signed [NUMERATOR_WIDTH-1:0]   remainder_in,
   input  logic                                valid_in,
   output logic signed [NUMERATOR_WIDTH-1:0]   numerator_out,
   output logic                                overflow_out,
   output logic                                check_fail_out,
   output logic                                valid_out
);

   localparam int unsigned NW    = NUMERATOR_WIDTH;
   localparam int unsigned DW    = DENOMINATOR_WIDTH;
   localparam int unsigned QW    = QUOTIENT_WIDTH;
   localparam int unsigned AW    = QW + DW;
   localparam int unsigned REC_W = lmul_rec_w(NW, DW, QW);
   // Sum width: exact for q*d+r, and at least NW+1 so the range test has a guard bit
   localparam int unsigned SW    = (QW + DW + 2 > NW + 1) ? (QW + DW + 2) : (NW + 1);
   localparam int unsigned HW    = SW - NW + 1;

   typedef struct packed {
      logic          valid;
      logic          neg;
      logic [QW-1:0] mag;
      logic [DW-1:0] denominator;
      logic [NW-1:0] remainder;
      logic [AW-1:0] acc;
   } rec_t;

   // -----------------------------------------------------------------------
   // Stage 0: sign/magnitude split of the quotient, capture the triple
   // -----------------------------------------------------------------------
   rec_t stage0_d;
   rec_t stage0_q;

   always_comb begin
      stage0_d             = '0;
      stage0_d.valid       = valid_in;
      stage0_d.neg         = quotient_in[QW-1];
      stage0_d.mag         = QW'(abs_mag(ABS_W'(quotient_in)));
      stage0_d.denominator = denominator_in;
      stage0_d.remainder   = remainder_in;
      stage0_d.acc         = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stage0_q <= '0;
      else       stage0_q <= stage0_d;
   end

   // -----------------------------------------------------------------------
   // Stages 1..Q: shift-add, MSB of the magnitude first
   // -----------------------------------------------------------------------
   rec_t pipe [0:QW];

   assign pipe[0] = stage0_q;

   for (genvar k = 1; k <= int'(QW); k++) begin : g_stage
      lmul_stage #(
         .NUMERATOR_WIDTH   (NW),
         .DENOMINATOR_WIDTH (DW),
         .QUOTIENT_WIDTH    (QW),
         .BIT_INDEX         (QW - k)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .rec_i (pipe[k-1]),
         .rec_o (pipe[k])
      );
   end

   // -----------------------------------------------------------------------
   // Output stage: apply sign, add remainder, range and consistency checks
   // -----------------------------------------------------------------------
   rec_t tail;
   assign tail = pipe[QW];

   logic signed [SW-1:0] acc_s;
   logic signed [SW-1:0] rem_s;
   logic signed [SW-1:0] sum_c;
   logic        [HW-1:0] hi_c;

   logic          valid_out_d;
   logic [NW-1:0] numerator_d;
   logic          overflow_d;
   logic          check_fail_d;

   always_comb begin
      acc_s       = $signed({{(SW - AW){1'b0}}, tail.acc});
      rem_s       = $signed({{(SW - NW){tail.remainder[NW-1]}}, tail.remainder});
      sum_c       = (tail.neg ? -acc_s : acc_s) + rem_s;
      // Fits NW signed bits iff every bit from NW-1 upward equals the sign
      hi_c        = sum_c[SW-1:NW-1];
      valid_out_d = tail.valid;
      numerator_d = sum_c[NW-1:0];
      overflow_d  = !((hi_c == '0) || (hi_c == '1));
   end

`ifdef LMUL_CHECK_EN
   localparam int unsigned CW = (NW > DW) ? NW : DW;

   logic [CW-1:0] rem_abs_c;
   logic [CW-1:0] den_ext_c;
   logic          rem_nz_c;

   // |r| < d (or r == 0 when d == 0), and a nonzero r shares the result's sign
   always_comb begin
      rem_abs_c    = CW'(NW'(abs_mag(ABS_W'($signed(tail.remainder)))));
      den_ext_c    = CW'(tail.denominator);
      rem_nz_c     = (tail.remainder != '0);
      check_fail_d = (tail.denominator != '0) ? (rem_abs_c >= den_ext_c) : rem_nz_c;
      if (rem_nz_c && (tail.remainder[NW-1] != sum_c[SW-1])) check_fail_d = 1'b1;
   end
`else
   always_comb begin
      check_fail_d = 1'b0;
   end
`endif

   // Magnitude bits are fully consumed by the last shift-add stage
   logic unused_tail;
   assign unused_tail = ^{tail.mag, tail.denominator};

   logic          valid_out_q;
   logic [NW-1:0] numerator_q;
   logic          overflow_q;
   logic          check_fail_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out_q  <= 1'b0;
         numerator_q  <= '0;
         overflow_q   <= 1'b0;
         check_fail_q <= 1'b0;
      end else begin
         valid_out_q  <= valid_out_d;
         numerator_q  <= numerator_d;
         overflow_q   <= overflow_d;
         check_fail_q <= check_fail_d;
      end
   end

   assign valid_out      = valid_out_q;
   assign numerator_out  = $signed(numerator_q);
   assign overflow_out   = overflow_q;
   assign check_fail_out = check_fail_q;

endmodule

// File: doc/lmul.md
# lmul

- Pipelined signed-by-unsigned shift-add multiply-accumulator: numerator = quotient × denominator + remainder.
- It is the inverse of the pipelined long divider. It recombines divider outputs (or any quotient/denominator/remainder triple) into the original signed numerator, and flags overflow.
- It sits downstream of the divider for self-checking datapaths, and standalone wherever a fixed-latency, one-result-per-clock multiply-add is needed.

## Interface
- NUMERATOR_WIDTH, default 10: width of signed remainder_in and numerator_out.
- DENOMINATOR_WIDTH, default 10: width of unsigned denominator_in.
- QUOTIENT_WIDTH, default 10: width of signed quotient_in; also the number of shift-add stages.
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- quotient_in, input, QUOTIENT_WIDTH: signed quotient.
- denominator_in, input, DENOMINATOR_WIDTH: unsigned denominator.
- remainder_in, input, NUMERATOR_WIDTH: signed remainder, sign follows numerator (truncating division).
- valid_in, input, 1: the triple is sampled on this edge.
- numerator_out, output, NUMERATOR_WIDTH: signed result, low bits of q×d+r.
- overflow_out, output, 1: the exact q×d+r is not representable in NUMERATOR_WIDTH signed bits.
- check_fail_out, output, 1: the triple is inconsistent with truncating division (see Configuration).
- valid_out, output, 1: the outputs above hold a result this cycle.

## Operation
- There is no backpressure. Every cycle with valid_in high produces exactly one valid_out cycle. Results leave in input order.
- Stage 0 (input register) captures:
  - mag = |quotient_in|, QUOTIENT_WIDTH unsigned. The most-negative quotient -2^(Q-1) maps to 2^(Q-1) and fits.
  - neg = quotient_in < 0.
  - denominator_in, remainder_in, valid_in.
- Stages 1..Q form the accumulator acc, unsigned, QUOTIENT_WIDTH+DENOMINATOR_WIDTH bits, zero at stage 0. It is processed MSB-first:
  - acc_i = (acc_{i-1} << 1) + (mag[Q-i] ? denominator : 0).
  - acc is exact and never wraps.
- Output stage computes sum = (neg ? -acc : acc) + sign-extended remainder.
  - sum is signed, Q+D+2 bits, and is always exact.
  - numerator_out = sum[NUMERATOR_WIDTH-1:0].
  - overflow_out = 1 when sum lies outside [-2^(N-1), 2^(N-1)-1].
- denominator = 0: acc = 0, so numerator_out = remainder.
- mag, neg, denominator, remainder and valid travel with each stage.
- Only the valid chain needs reset. Data registers may be reset as well.
- The datapath follows the no-stall rule: no stage ever holds; every register advances every clock.

## Timing
- Register depth is Q+2: stage 0, stages 1..Q, output stage.
- A triple sampled at edge t appears on the outputs right after edge t+Q+1.
- Throughput is one result per clock. Back-to-back valid_in is fully supported.
- valid_out is registered and asserts only in cycles carrying a result. Output data is don't-care while valid_out=0.
- Reset values:
  - numerator_out=0, overflow_out=0, check_fail_out=0, valid_out=0.
  - All internal valid bits are 0.
- Reset takes effect immediately and asynchronously. In-flight results are discarded, never emitted late.
- After reset deasserts, the first valid_out occurs Q+2 edges after the first sampled valid_in.
- valid_in coincident with the reset-release edge is not guaranteed to be sampled. Drive valid_in=0 across reset release.

## Configuration
- LMUL_CHECK_EN defined:
  - The output stage additionally registers check_fail_out.
  - check_fail_out = (denominator != 0 ? |remainder| >= denominator : remainder != 0).
  - It is also set when remainder != 0 and the remainder's sign differs from the sign of the exact sum.
- LMUL_CHECK_EN undefined:
  - check_fail_out is tied to 0.
  - No comparator logic is built.
  - All other behaviour and timing are identical.

## Structure
- Shared package ldiv_pkg holds:
  - function lmul_latency(qw) returning qw+2;
  - function abs_mag for sign/magnitude split, reused by the divider;
  - the stage-record typedef {valid, neg, mag, denominator, remainder, acc}.
- One sub-module, lmul_stage: a single shift-add stage parameterised by bit index, generated Q times.
- Stage 0 and the output stage live in the lmul top.

## Test plan
- Defaults; q=7, d=13, r=5, single valid_in pulse -> numerator_out=96, overflow_out=0, valid_out high exactly one cycle after edge t+11.
- q=-7, d=13, r=-5 -> numerator_out=-96, overflow_out=0.
- q=-512, d=1, r=0 -> -512, overflow_out=0. Then q=-512, d=2, r=0 -> numerator_out=0, overflow_out=1. Then q=255, d=2, r=1 -> 511, overflow_out=0.
- 200 consecutive valid_in cycles with random consistent triples (from a reference q=n/d, r=n%d, d≠0) -> 200 consecutive valid_out, in order, numerator_out=n, overflow_out=0.
- Stream running; reset pulsed for 1 cycle mid-stream -> valid_out drops to 0 immediately with no clock, no stale result appears afterward, and the next result comes Q+2 edges after the next valid_in.
- With LMUL_CHECK_EN:
  - q=3, d=4, r=4 -> check_fail_out=1, numerator_out=16.
  - q=3, d=0, r=0 -> check_fail_out=0, numerator_out=0.
  - Without the macro, check_fail_out=0 for both.
